serial_sum8_signed: RTL and testbench

SERIAL_SUM8_SIGNED -- requirements
Module: serial_sum8_signed

---
 rtl/serial_sum_pkg.sv | 7 +
 rtl/sum_acc_dp.sv | 20 ++
 rtl/serial_sum8_signed.sv | 55 +++++
 tb/tb_serial_sum8_signed.sv | 117 +++++++++++
 4 files changed

// File: rtl/serial_sum_pkg.sv
// serial_sum_pkg: shared constants and FSM state type for the serial signed summer.
package serial_sum_pkg;
  localparam int N_OPS = 8;
  localparam int CNT_W = 3;
  localparam int EXT_W = 3;
  typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/sum_acc_dp.sv
// sum_acc_dp: sign-extending accumulator; sum is the running total including the current operand.
module sum_acc_dp
  import serial_sum_pkg::*;
#(
  parameter int width = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [width-1:0]       data,
  output logic [width+EXT_W-1:0] sum
);
  logic [width+EXT_W-1:0] acc;
  always_comb sum = acc + {{EXT_W{data[width-1]}}, data};
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en) acc <= sum;
  end
endmodule

// File: rtl/serial_sum8_signed.sv
// serial_sum8_signed: sums groups of 8 signed operands; SUM_LAST_EN adds s_last to close a group early.
module serial_sum8_signed
  import serial_sum_pkg::*;
#(
  parameter int width = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [width-1:0]       s_data,
`ifdef SUM_LAST_EN
  input  logic                   s_last,
`endif
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [width+EXT_W-1:0] m_data
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic accept, close;
  logic [width+EXT_W-1:0] sum;
  always_comb s_ready = state == ACCUM;
  always_comb m_valid = state == HOLD;
  always_comb accept = s_valid && s_ready;
`ifdef SUM_LAST_EN
  always_comb close = accept && (s_last || cnt == CNT_W'(N_OPS - 1));
`else
  always_comb close = accept && cnt == CNT_W'(N_OPS - 1);
`endif
  // Accumulator clears as the group closes; m_data carries the result through HOLD.
  sum_acc_dp #(.width(width)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .clr  (close),
    .en   (accept),
    .data (s_data),
    .sum  (sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      cnt    <= '0;
      m_data <= '0;
    end else if (state == ACCUM) begin
      if (accept) cnt <= close ? '0 : cnt + 1'b1;
      if (close) begin
        state  <= HOLD;
        m_data <= sum;
      end
    end else if (m_ready) begin
      state <= ACCUM;
    end
  end
endmodule

// File: tb/tb_serial_sum8_signed.sv
// tb_serial_sum8_signed: directed checks of serial_sum8_signed; covers SUM_LAST_EN when defined.
module tb_serial_sum8_signed;
  logic clk = 0, rst = 1, s_valid = 0, s_ready, m_valid, m_ready = 0, s_last = 0;
  logic [16:0] s_data = '0;
  logic [19:0] m_data;
  int vectors = 0, miscompares = 0;
  serial_sum8_signed dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
`ifdef SUM_LAST_EN
    .s_last  (s_last),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [16:0] d, input int gap);
    repeat (gap) step();
    s_valid = 1;
    s_data = d;
    step();
    s_valid = 0;
  endtask
  task automatic group(input string tag, input logic [16:0] d, input logic [19:0] exp);
    for (int i = 0; i < 7; i++) op(d, 0);
    check({tag, "_pre_valid"}, 20'(m_valid), 20'd0);
    op(d, 0);
    check({tag, "_valid"}, 20'(m_valid), 20'd1);
    check({tag, "_ready"}, 20'(s_ready), 20'd0);
    check({tag, "_data"}, m_data, exp);
  endtask
  task automatic drain(input string tag);
    m_ready = 1;
    step();
    m_ready = 0;
    check({tag, "_drained"}, 20'(m_valid), 20'd0);
    check({tag, "_reopen"}, 20'(s_ready), 20'd1);
  endtask
  initial begin
    int sum;
    logic [16:0] d;
    step();
    step();
    check("rst_valid", 20'(m_valid), 20'd0);
    check("rst_data", m_data, 20'd0);
    rst = 0;
    check("rst_fall_ready", 20'(s_ready), 20'd1);
    m_ready = 1;
    group("ones", 17'h00001, 20'h00008);
    step();
    check("ones_drained", 20'(m_valid), 20'd0);
    check("ones_reopen", 20'(s_ready), 20'd1);
    m_ready = 0;
    group("neg_max", 17'h10000, 20'h80000);
    drain("neg_max");
    group("pos_max", 17'h0FFFF, 20'h7FFF8);
    s_valid = 1;
    s_data = 17'h00123;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_data", m_data, 20'h7FFF8);
      check("hold_ready", 20'(s_ready), 20'd0);
      check("hold_valid", 20'(m_valid), 20'd1);
    end
    s_valid = 0;
    drain("pos_max");
    check("idle_data_kept", m_data, 20'h7FFF8);
    for (int i = 0; i < 3; i++) op(17'h00005, 0);
    rst = 1;
    step();
    rst = 0;
    check("midrst_data", m_data, 20'd0);
    check("midrst_ready", 20'(s_ready), 20'd1);
    group("after_rst", 17'h00001, 20'h00008);
    drain("after_rst");
    for (int r = 0; r < 3; r++) begin
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        d = 17'($urandom);
        sum += int'($signed(d));
        op(d, $urandom_range(0, 3));
      end
      check("rand_valid", 20'(m_valid), 20'd1);
      check("rand_data", m_data, 20'(sum));
      drain("rand");
    end
`ifdef SUM_LAST_EN
    op(17'h00005, 0);
    op(17'h1FFFE, 1);
    s_last = 1;
    op(17'h00007, 0);
    s_last = 0;
    check("last_valid", 20'(m_valid), 20'd1);
    check("last_data", m_data, 20'h0000A);
    drain("last");
    group("after_last", 17'h00001, 20'h00008);
    drain("after_last");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
